// File: rtl/ft245_out_arbiter.sv
// Packet-atomic round-robin arbiter sharing the FT245 out FIFO between a command-response
// requester (0) and an interrupt/status requester (1), with timeout padding for stalled sources.
module ft245_out_arbiter #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r0_req,
    input  logic [LEN_WIDTH-1:0] r0_len,
    input  logic [7:0]           r0_data,
    input  logic                 r0_valid,
    output logic                 r0_rd,
    output logic                 r0_grant,
    output logic                 r0_done,
    output logic                 r0_timeout,
    input  logic                 r1_req,
    input  logic [LEN_WIDTH-1:0] r1_len,
    input  logic [7:0]           r1_data,
    input  logic                 r1_valid,
    output logic                 r1_rd,
    output logic                 r1_grant,
    output logic                 r1_done,
    output logic                 r1_timeout,
    input  logic                 out_fifo_full,
    output logic                 out_fifo_wr,
    output logic [7:0]           out_fifo_data,
    output logic                 busy
);

    localparam int unsigned STARVE_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_LAST = STARVE_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StXfer, StPad, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic                    timeout_q, timeout_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [STARVE_WIDTH-1:0] starve_q, starve_d;

    logic                 cur_valid;
    logic [7:0]           cur_data;
    logic                 accept;
    logic                 pick;
    logic [LEN_WIDTH-1:0] pick_len;

    assign cur_valid = owner_q ? r1_valid : r0_valid;
    assign cur_data  = owner_q ? r1_data : r0_data;
    assign pick      = (r0_req & r1_req) ? ~last_q : r1_req;
    assign pick_len  = pick ? r1_len : r0_len;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        timeout_d     = timeout_q;
        remaining_d   = remaining_q;
        starve_d      = starve_q;
        accept        = 1'b0;
        out_fifo_wr   = 1'b0;
        out_fifo_data = cur_data;
        unique case (state_q)
            StIdle: begin
                if (r0_req | r1_req) begin
                    owner_d     = pick;
                    remaining_d = pick_len;
                    starve_d    = '0;
                    timeout_d   = 1'b0;
                    state_d     = (pick_len == '0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                // Gating with rst stops the write in the very cycle reset is applied.
                accept      = cur_valid & ~out_fifo_full & ~rst;
                out_fifo_wr = accept;
                if (accept) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    starve_d    = '0;
                    if (remaining_q == LEN_WIDTH'(1)) state_d = StDone;
                end else if (!cur_valid && !out_fifo_full) begin
                    starve_d = starve_q + STARVE_WIDTH'(1);
                    if (starve_q == STARVE_LAST) begin
                        state_d   = StPad;
                        timeout_d = 1'b1;
                    end
                end
            end
            StPad: begin
                out_fifo_data = PAD_BYTE;
                out_fifo_wr   = ~out_fifo_full & ~rst;
                if (out_fifo_wr) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) state_d = StDone;
                end
            end
            StDone: begin
                last_d    = owner_q;
                timeout_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            timeout_q   <= 1'b0;
            remaining_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            timeout_q   <= timeout_d;
            remaining_q <= remaining_d;
            starve_q    <= starve_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign r0_rd      = accept & ~owner_q;
    assign r1_rd      = accept & owner_q;
    assign r0_grant   = busy & ~owner_q;
    assign r1_grant   = busy & owner_q;
    assign r0_done    = (state_q == StDone) & ~owner_q;
    assign r1_done    = (state_q == StDone) & owner_q;
    assign r0_timeout = r0_done & timeout_q;
    assign r1_timeout = r1_done & timeout_q;

endmodule

// File: tb/tb_ft245_out_arbiter.sv
// Bench for ft245_out_arbiter: vector table, directed corner sequences and a random run
// checked against a packet-level reference model.
module tb_ft245_out_arbiter;

    localparam int          LW  = 16;
    localparam int          TMO = 8;
    localparam logic [7:0]  PAD = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_valid, r0_rd, r0_grant, r0_done, r0_timeout;
    logic [LW-1:0] r0_len;
    logic [7:0]    r0_data;
    logic          r1_req, r1_valid, r1_rd, r1_grant, r1_done, r1_timeout;
    logic [LW-1:0] r1_len;
    logic [7:0]    r1_data;
    logic          out_fifo_full, out_fifo_wr, busy;
    logic [7:0]    out_fifo_data;

    always #5 clk = ~clk;

    ft245_out_arbiter #(.LEN_WIDTH(LW), .TIMEOUT(TMO), .PAD_BYTE(PAD)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_len(r0_len), .r0_data(r0_data), .r0_valid(r0_valid),
        .r0_rd(r0_rd), .r0_grant(r0_grant), .r0_done(r0_done), .r0_timeout(r0_timeout),
        .r1_req(r1_req), .r1_len(r1_len), .r1_data(r1_data), .r1_valid(r1_valid),
        .r1_rd(r1_rd), .r1_grant(r1_grant), .r1_done(r1_done), .r1_timeout(r1_timeout),
        .out_fifo_full(out_fifo_full), .out_fifo_wr(out_fifo_wr),
        .out_fifo_data(out_fifo_data), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_len = '0; r0_data = '0; r0_valid = 0;
        r1_req = 0; r1_len = '0; r1_data = '0; r1_valid = 0;
        out_fifo_full = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // exp bits: {wr, r0_rd, r0_grant, r0_done, r0_timeout, busy}
    typedef struct {
        logic       req;
        logic [15:0] len;
        logic       valid;
        logic [7:0] data;
        logic       full;
        logic [5:0] exp;
        logic [7:0] odata;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic req, input logic [15:0] len, input logic valid,
                                input logic [7:0] data, input logic full,
                                input logic [5:0] exp, input logic [7:0] odata);
        vec_t v;
        v.req = req; v.len = len; v.valid = valid; v.data = data; v.full = full;
        v.exp = exp; v.odata = odata;
        tbl.push_back(v);
    endfunction

    // Random-phase source and model state
    int  src_act[2], src_len[2], src_sent[2], src_stall[2], src_gap[2], src_pkt[2];
    bit  rd_seen[2], done_seen[2], grant_seen[2];
    int  m_phase, m_own, m_len, m_wr, m_starve, m_last, m_pkts;
    bit  m_pad;

    task automatic drive_random();
        logic          v[2];
        logic [7:0]    d[2];
        logic [LW-1:0] l[2];
        for (int n = 0; n < 2; n++) begin
            if (rd_seen[n]) src_sent[n]++;
            if (done_seen[n]) begin
                src_act[n] = 0;
                src_gap[n] = $urandom_range(0, 4);
            end else if (src_act[n] == 0) begin
                if (src_gap[n] == 0) begin
                    src_act[n]  = 1;
                    src_len[n]  = $urandom_range(0, 6);
                    src_sent[n] = 0;
                    src_pkt[n]++;
                end else begin
                    src_gap[n]--;
                end
            end
            if (src_stall[n] > 0) begin
                src_stall[n]--;
                v[n] = 0;
            end else if ($urandom_range(0, 24) == 0) begin
                src_stall[n] = $urandom_range(3, 13);
                v[n] = 0;
            end else begin
                v[n] = ($urandom_range(0, 3) != 0);
            end
            d[n] = 8'(n * 128 + (src_pkt[n] % 8) * 16 + src_sent[n]);
            l[n] = grant_seen[n] ? LW'($urandom) : LW'(src_len[n]);
        end
        r0_req = (src_act[0] != 0); r0_len = l[0]; r0_valid = v[0]; r0_data = d[0];
        r1_req = (src_act[1] != 0); r1_len = l[1]; r1_valid = v[1]; r1_data = d[1];
        out_fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic sample_random();
        logic [9:0] act_v, exp_v;
        logic [7:0] exp_d, cur_data;
        logic       exp_wr, cur_valid;
        act_v = {r1_grant, r0_grant, r1_done, r0_done, r1_timeout, r0_timeout,
                 r1_rd, r0_rd, out_fifo_wr, busy};
        exp_v = '0;
        exp_wr = 0;
        exp_d = '0;
        cur_valid = (m_own == 1) ? r1_valid : r0_valid;
        cur_data  = (m_own == 1) ? r1_data : r0_data;
        if (m_phase == 1) begin
            exp_v[8 + m_own] = 1;
            exp_v[0] = 1;
            if (m_pad) begin
                exp_wr = !out_fifo_full;
                exp_d  = PAD;
            end else begin
                exp_wr = cur_valid && !out_fifo_full;
                exp_d  = cur_data;
                exp_v[2 + m_own] = exp_wr;
            end
            exp_v[1] = exp_wr;
        end else if (m_phase == 2) begin
            exp_v[8 + m_own] = 1;
            exp_v[6 + m_own] = 1;
            exp_v[4 + m_own] = m_pad;
            exp_v[0] = 1;
        end
        chk("rand_ctl", 32'(act_v), 32'(exp_v));
        if (exp_wr) chk("rand_data", 32'(out_fifo_data), 32'(exp_d));
        rd_seen[0] = r0_rd;       rd_seen[1] = r1_rd;
        done_seen[0] = r0_done;   done_seen[1] = r1_done;
        grant_seen[0] = r0_grant; grant_seen[1] = r1_grant;
        // Advance the packet-level model to the next cycle.
        if (m_phase == 0) begin
            if (r0_req || r1_req) begin
                m_own = (r0_req && r1_req) ? 1 - m_last : (r1_req ? 1 : 0);
                m_len = (m_own == 1) ? int'(r1_len) : int'(r0_len);
                m_wr = 0; m_starve = 0; m_pad = 0;
                m_phase = (m_len == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (exp_wr) begin
                m_wr++;
                m_starve = 0;
                if (m_wr == m_len) m_phase = 2;
            end else if (!m_pad && !cur_valid && !out_fifo_full) begin
                m_starve++;
                if (m_starve == TMO) m_pad = 1;
            end
        end else begin
            m_last = m_own;
            m_phase = 0;
            m_pkts++;
        end
    endtask

    initial begin
        logic [7:0] wq[$];
        int         wc[$];
        int         cnt0, cnt1, dones, cyc, sent, wcount;
        bit         seen_done, seen_tmo;
        logic [7:0] exp_cont[8];

        do_reset();

        // Single packet followed by backpressure packet.
        add(0, 0, 0, 8'h00, 0, 6'b000000, 8'h00);
        add(1, 3, 1, 8'hA1, 0, 6'b000000, 8'h00);
        add(1, 3, 1, 8'hA1, 0, 6'b111001, 8'hA1);
        add(1, 3, 1, 8'hA2, 0, 6'b111001, 8'hA2);
        add(1, 3, 1, 8'hA3, 0, 6'b111001, 8'hA3);
        add(1, 3, 0, 8'h00, 0, 6'b001101, 8'h00);
        add(0, 3, 0, 8'h00, 0, 6'b000000, 8'h00);
        add(1, 4, 1, 8'hB1, 0, 6'b000000, 8'h00);
        add(1, 4, 1, 8'hB1, 0, 6'b111001, 8'hB1);
        add(1, 9, 1, 8'hB2, 0, 6'b111001, 8'hB2);
        for (int i = 0; i < 5; i++) add(1, 9, 1, 8'hB3, 1, 6'b001001, 8'h00);
        for (int i = 0; i < 10; i++) add(1, 9, 0, 8'hB3, 1, 6'b001001, 8'h00);
        add(1, 9, 1, 8'hB3, 0, 6'b111001, 8'hB3);
        add(1, 9, 1, 8'hB4, 0, 6'b111001, 8'hB4);
        add(1, 9, 0, 8'h00, 0, 6'b001101, 8'h00);
        add(0, 0, 0, 8'h00, 0, 6'b000000, 8'h00);

        foreach (tbl[i]) begin
            r0_req = tbl[i].req; r0_len = tbl[i].len; r0_valid = tbl[i].valid;
            r0_data = tbl[i].data; out_fifo_full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({out_fifo_wr, r0_rd, r0_grant, r0_done, r0_timeout, busy}),
                32'(tbl[i].exp));
            chk($sformatf("vec%0d_r1", i), 32'({r1_rd, r1_grant, r1_done}), 32'(0));
            if (tbl[i].exp[5]) chk($sformatf("vec%0d_data", i), 32'(out_fifo_data),
                                   32'(tbl[i].odata));
            @(posedge clk); #1;
        end
        idle_inputs();

        // Contention with both requests held: grants must alternate r0, r1, r0, r1.
        do_reset();
        cnt0 = 0; cnt1 = 0; dones = 0;
        wq.delete();
        r0_req = 1; r1_req = 1; r0_len = 2; r1_len = 2; r0_valid = 1; r1_valid = 1;
        for (cyc = 0; cyc < 40 && dones < 4; cyc++) begin
            r0_data = 8'(8'h10 + cnt0);
            r1_data = 8'(8'h20 + cnt1);
            @(negedge clk);
            if (out_fifo_wr) wq.push_back(out_fifo_data);
            if (r0_rd) cnt0++;
            if (r1_rd) cnt1++;
            if (r0_done || r1_done) dones++;
            @(posedge clk); #1;
        end
        idle_inputs();
        exp_cont = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        chk("cont_dones", dones, 4);
        chk("cont_writes", wq.size(), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk($sformatf("cont_byte%0d", i), 32'(wq[i]), 32'(exp_cont[i]));
        @(posedge clk); #1;

        // Timeout padding: 2 real bytes then starvation.
        wq.delete(); wc.delete();
        sent = 0; seen_done = 0; seen_tmo = 0;
        r0_req = 1; r0_len = 5;
        for (cyc = 0; cyc < 60 && !seen_done; cyc++) begin
            r0_valid = (sent < 2);
            r0_data = 8'(8'hC0 + sent);
            @(negedge clk);
            if (out_fifo_wr) begin
                wq.push_back(out_fifo_data);
                wc.push_back(cyc);
            end
            if (r0_rd) sent++;
            if (r0_done) begin
                seen_done = 1;
                seen_tmo = r0_timeout;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("tmo_done", seen_done, 1);
        chk("tmo_flag", seen_tmo, 1);
        chk("tmo_writes", wq.size(), 5);
        if (wq.size() == 5) begin
            chk("tmo_b0", 32'(wq[0]), 32'hC0);
            chk("tmo_b1", 32'(wq[1]), 32'hC1);
            for (int i = 2; i < 5; i++) chk($sformatf("tmo_pad%0d", i), 32'(wq[i]), 32'(PAD));
            chk("tmo_gap", wc[2] - wc[1], TMO + 1);
            chk("tmo_padrun", wc[4] - wc[2], 2);
        end

        // Zero-length packet on requester 1.
        r1_req = 1; r1_len = 0;
        @(negedge clk);
        chk("zero_idle", 32'({r1_grant, out_fifo_wr}), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_done", 32'({r1_grant, r1_done, r1_timeout, out_fifo_wr, r1_rd}),
            32'(5'b11000));
        @(posedge clk); #1;
        r1_req = 0;
        @(negedge clk);
        chk("zero_after", 32'({busy, r1_grant, out_fifo_wr}), 32'(0));
        @(posedge clk); #1;

        // Reset in the middle of a 10-byte packet.
        wcount = 0; sent = 0;
        r0_req = 1; r0_len = 10; r0_valid = 1;
        for (cyc = 0; cyc < 20 && wcount < 4; cyc++) begin
            r0_data = 8'(8'hD0 + sent);
            @(negedge clk);
            if (out_fifo_wr) wcount++;
            if (r0_rd) sent++;
            @(posedge clk); #1;
        end
        chk("rstmid_pre", wcount, 4);
        rst = 1; r0_req = 0;
        @(negedge clk);
        chk("rstmid_cycle", 32'({out_fifo_wr, r0_rd, r0_done}), 32'(0));
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_after%0d", i),
                32'({out_fifo_wr, r0_grant, r1_grant, r0_done, busy}), 32'(0));
            @(posedge clk); #1;
        end
        wcount = 0; sent = 0; seen_done = 0; seen_tmo = 0;
        r0_req = 1; r0_len = 2;
        for (cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            r0_data = 8'(8'hE0 + sent);
            @(negedge clk);
            if (out_fifo_wr) begin
                chk("rstmid_new_data", 32'(out_fifo_data), 32'(8'hE0 + sent));
                wcount++;
            end
            if (r0_rd) sent++;
            if (r0_done) begin
                seen_done = 1;
                seen_tmo = r0_timeout;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("rstmid_new_done", seen_done, 1);
        chk("rstmid_new_writes", wcount, 2);
        chk("rstmid_new_tmo", seen_tmo, 0);

        // Random traffic against the packet-level model.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            src_act[n] = 0; src_len[n] = 0; src_sent[n] = 0; src_stall[n] = 0;
            src_gap[n] = $urandom_range(0, 3); src_pkt[n] = 0;
            rd_seen[n] = 0; done_seen[n] = 0; grant_seen[n] = 0;
        end
        m_phase = 0; m_own = 0; m_len = 0; m_wr = 0; m_starve = 0; m_last = 1;
        m_pkts = 0; m_pad = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            @(negedge clk);
            sample_random();
            @(posedge clk); #1;
        end
        chk("rand_progress", 32'(m_pkts > 50), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
